siren_driver: RTL and testbench

//   Downstream of the anti-theft FSM and timer. Consumes the FSM siren request
//   (eneble_siren) and the timer 2 Hz strobe (two_hz_enable).

---
 rtl/siren_driver.sv | 153 +++++++++++++++
 tb/tb_siren_driver.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/siren_driver.sv
// Siren and RGB indicator driver that alternates at the 2 Hz strobe and caps each alarm episode.
// Optional audible tone output and divider are enabled by defining SIREN_TONE_EN.
module siren_driver #(
    parameter int CNT_W            = 8,
    parameter int MAX_HALF_PERIODS = 60,
    parameter int TONE_DIV         = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             eneble_siren,
    input  logic             two_hz_enable,
    output logic             siren,
    output logic [2:0]       color,
    output logic             siren_active,
`ifdef SIREN_TONE_EN
    output logic [CNT_W-1:0] episode_count,
    output logic             tone
`else
    output logic [CNT_W-1:0] episode_count
`endif
);

    // state    | meaning
    // IDLE     | no alarm requested, outputs dark
    // ALARM_HI | siren on, red
    // ALARM_LO | siren off, blue
    // HOLDOFF  | episode limit reached, green until request drops
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ALARM_HI = 2'd1;
    localparam logic [1:0] ST_ALARM_LO = 2'd2;
    localparam logic [1:0] ST_HOLDOFF  = 2'd3;

    localparam bit               LIMITED = (MAX_HALF_PERIODS != 0);
    localparam logic [CNT_W:0]   MAX_EXT = (CNT_W+1)'(MAX_HALF_PERIODS);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HALF_PERIODS);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W:0]   count_inc;
    logic             siren_q, siren_d;
    logic [2:0]       color_q, color_d;
    logic             active_q, active_d;

    assign count_inc = {1'b0, count_q} + 1'b1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (eneble_siren) begin
                    state_d = ST_ALARM_HI;
                    count_d = '0;
                end
            end
            ST_ALARM_HI, ST_ALARM_LO: begin
                // Dropping the request wins over a coincident strobe.
                if (!eneble_siren) begin
                    state_d = ST_IDLE;
                end else if (two_hz_enable) begin
                    if (LIMITED && (count_inc == MAX_EXT)) begin
                        state_d = ST_HOLDOFF;
                        count_d = MAX_CNT;
                    end else begin
                        state_d = (state_q == ST_ALARM_HI) ? ST_ALARM_LO : ST_ALARM_HI;
                        if (count_q != '1) count_d = count_inc[CNT_W-1:0];
                    end
                end
            end
            ST_HOLDOFF: begin
                if (!eneble_siren) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge as the state.
    always_comb begin
        siren_d  = 1'b0;
        color_d  = 3'b000;
        active_d = 1'b0;
        case (state_d)
            ST_ALARM_HI: begin
                siren_d  = 1'b1;
                color_d  = 3'b100;
                active_d = 1'b1;
            end
            ST_ALARM_LO: begin
                color_d  = 3'b001;
                active_d = 1'b1;
            end
            ST_HOLDOFF: color_d = 3'b010;
            default:    color_d = 3'b000;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            siren_q  <= 1'b0;
            color_q  <= 3'b000;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            siren_q  <= siren_d;
            color_q  <= color_d;
            active_q <= active_d;
        end
    end

    assign siren         = siren_q;
    assign color         = color_q;
    assign siren_active  = active_q;
    assign episode_count = count_q;

`ifdef SIREN_TONE_EN
    localparam int               DIV_W    = $clog2(TONE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TONE_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tone_q, tone_d;

    // Divider only runs while staying in ALARM_HI; any other cycle clears it and silences the tone.
    always_comb begin
        div_d  = '0;
        tone_d = 1'b0;
        if ((state_q == ST_ALARM_HI) && (state_d == ST_ALARM_HI)) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                tone_d = ~tone_q;
            end else begin
                div_d  = div_q + 1'b1;
                tone_d = tone_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;
`endif

endmodule

// File: tb/tb_siren_driver.sv
// Directed self-checking bench for siren_driver: default, limited (3) and narrow saturating instances.
// The tone checks are compiled in only when SIREN_TONE_EN is defined.
module tb_siren_driver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       strobe = 1'b0;
    logic       en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;

    logic       siren_a, siren_b, siren_c;
    logic [2:0] color_a, color_b, color_c;
    logic       act_a, act_b, act_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
`ifdef SIREN_TONE_EN
    logic       tone_a, tone_b, tone_c;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    siren_driver #(.CNT_W(8), .MAX_HALF_PERIODS(60), .TONE_DIV(4)) u_dut (
        .clock(clock), .reset(reset), .eneble_siren(en_a), .two_hz_enable(strobe),
        .siren(siren_a), .color(color_a), .siren_active(act_a),
`ifdef SIREN_TONE_EN
        .tone(tone_a),
`endif
        .episode_count(cnt_a));

    siren_driver #(.CNT_W(8), .MAX_HALF_PERIODS(3), .TONE_DIV(4)) u_lim (
        .clock(clock), .reset(reset), .eneble_siren(en_b), .two_hz_enable(strobe),
        .siren(siren_b), .color(color_b), .siren_active(act_b),
`ifdef SIREN_TONE_EN
        .tone(tone_b),
`endif
        .episode_count(cnt_b));

    siren_driver #(.CNT_W(2), .MAX_HALF_PERIODS(0), .TONE_DIV(4)) u_sat (
        .clock(clock), .reset(reset), .eneble_siren(en_c), .two_hz_enable(strobe),
        .siren(siren_c), .color(color_c), .siren_active(act_c),
`ifdef SIREN_TONE_EN
        .tone(tone_c),
`endif
        .episode_count(cnt_c));

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // siren, color, active, count of one instance in a single call
    task automatic chk_out(input string tag, input logic s, input logic [2:0] c, input logic a,
                           input logic [7:0] n, input logic es, input logic [2:0] ec,
                           input logic ea, input logic [7:0] en);
        chk({tag, ".siren"}, {7'd0, s}, {7'd0, es});
        chk({tag, ".color"}, {5'd0, c}, {5'd0, ec});
        chk({tag, ".active"}, {7'd0, a}, {7'd0, ea});
        chk({tag, ".count"}, n, en);
    endtask

    initial begin
        // Reset held with the request asserted.
        en_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("reset", siren_a, color_a, act_a, cnt_a, 1'b0, 3'b000, 1'b0, 8'd0);
        end
        reset = 1'b0;
        tick();
        chk_out("entry_hi", siren_a, color_a, act_a, cnt_a, 1'b1, 3'b100, 1'b1, 8'd0);

`ifdef SIREN_TONE_EN
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("tone_k%0d", k), {7'd0, tone_a}, (k >= 4 && k < 8) ? 8'd1 : 8'd0);
        end
`endif

        // Four strobes ten clocks apart: LO, HI, LO, HI.
        for (int i = 1; i <= 4; i++) begin
            tick(9);
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
            if (i % 2 == 1)
                chk_out($sformatf("basic_s%0d", i), siren_a, color_a, act_a, cnt_a,
                        1'b0, 3'b001, 1'b1, 8'(i));
            else
                chk_out($sformatf("basic_s%0d", i), siren_a, color_a, act_a, cnt_a,
                        1'b1, 3'b100, 1'b1, 8'(i));
`ifdef SIREN_TONE_EN
            if (i == 1) chk("tone_lo", {7'd0, tone_a}, 8'd0);
`endif
        end

        // Request drops in the same cycle as a strobe.
        en_a = 1'b0;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        chk_out("simul", siren_a, color_a, act_a, cnt_a, 1'b0, 3'b000, 1'b0, 8'd4);
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        chk_out("idle_strobe", siren_a, color_a, act_a, cnt_a, 1'b0, 3'b000, 1'b0, 8'd4);

        // Limit of three half-periods, two extra strobes ignored in HOLDOFF.
        en_b = 1'b1;
        tick();
        chk_out("lim_entry", siren_b, color_b, act_b, cnt_b, 1'b1, 3'b100, 1'b1, 8'd0);
        for (int i = 1; i <= 5; i++) begin
            tick(2);
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
            if (i >= 3)
                chk_out($sformatf("lim_s%0d", i), siren_b, color_b, act_b, cnt_b,
                        1'b0, 3'b010, 1'b0, 8'd3);
            else if (i == 1)
                chk_out("lim_s1", siren_b, color_b, act_b, cnt_b, 1'b0, 3'b001, 1'b1, 8'd1);
            else
                chk_out("lim_s2", siren_b, color_b, act_b, cnt_b, 1'b1, 3'b100, 1'b1, 8'd2);
        end
        // Re-arm through a single idle clock.
        en_b = 1'b0;
        tick();
        chk_out("lim_idle", siren_b, color_b, act_b, cnt_b, 1'b0, 3'b000, 1'b0, 8'd3);
        en_b = 1'b1;
        tick();
        chk_out("rearm", siren_b, color_b, act_b, cnt_b, 1'b1, 3'b100, 1'b1, 8'd0);
        en_b = 1'b0;
        tick();

        // Unlimited 2-bit counter saturates at 3.
        en_c = 1'b1;
        tick();
        for (int i = 1; i <= 5; i++) begin
            strobe = 1'b1;
            tick();
            strobe = 1'b0;
            chk($sformatf("sat_cnt%0d", i), {6'd0, cnt_c}, (i > 3) ? 8'd3 : 8'(i));
            chk($sformatf("sat_siren%0d", i), {7'd0, siren_c}, (i % 2 == 0) ? 8'd1 : 8'd0);
        end

        // Reset mid-episode.
        reset = 1'b1;
        tick();
        chk_out("mid_reset", siren_c, color_c, act_c, {6'd0, cnt_c}, 1'b0, 3'b000, 1'b0, 8'd0);
        reset = 1'b0;
        tick();
        chk_out("post_reset", siren_c, color_c, act_c, {6'd0, cnt_c}, 1'b1, 3'b100, 1'b1, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
